// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the data memory.
interface mem_arbiter_if;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifAck;
    logic [31:0] ifData;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic        dAck;
    logic [31:0] dRData;
    logic        dErr;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    modport slave (
        input  ifReq, ifAddr, dReq, dWe, dAddr, dWData, memReadData,
        output ifAck, ifData, dAck, dRData, dErr,
        output memRead, memWrite, memAddress, memWriteData
    );

    modport master (
        output ifReq, ifAddr, dReq, dWe, dAddr, dWData, memReadData,
        input  ifAck, ifData, dAck, dRData, dErr,
        input  memRead, memWrite, memAddress, memWriteData
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of a single big-endian data memory.
module mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input logic           clk,
    input logic           resetN,
    mem_arbiter_if.slave  bus
);
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(ACCESS_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e        state_q;
    logic [CW-1:0] wait_q;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          gnt_data_q;
    logic          we_q;
    logic          if_ack_q;
    logic [31:0]   if_data_q;
    logic          d_ack_q;
    logic [31:0]   d_rdata_q;
    logic          d_err_q;
    logic          rd_q;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          pick_data_d;
    logic          any_req_d;
    logic          misalign_d;

    always_comb begin
        any_req_d   = bus.dReq | bus.ifReq;
        misalign_d  = bus.dAddr[1:0] != 2'b00;
        pick_data_d = bus.dReq & ~(bus.ifReq & (starve_q == STARVE_MAX));
        starve_d    = starve_q;
        // fetch grants clear the count; data grants over a waiting fetch bump it
        if (any_req_d) begin
            if (!pick_data_d)
                starve_d = '0;
            else if (bus.ifReq && starve_q != STARVE_MAX)
                starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            starve_q   <= '0;
            gnt_data_q <= 1'b0;
            we_q       <= 1'b0;
            if_ack_q   <= 1'b0;
            if_data_q  <= '0;
            d_ack_q    <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        starve_q   <= starve_d;
                        gnt_data_q <= pick_data_d;
                        if (pick_data_d && misalign_d) begin
                            d_ack_q <= 1'b1;
                            d_err_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            we_q    <= pick_data_d & bus.dWe;
                            addr_q  <= pick_data_d ? bus.dAddr
                                                   : (bus.ifAddr & 32'hFFFF_FFFC);
                            wdata_q <= bus.dWData;
                            rd_q    <= ~(pick_data_d & bus.dWe);
                            wr_q    <= pick_data_d & bus.dWe;
                            wait_q  <= '0;
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_q == WAIT_LAST) begin
                        rd_q <= 1'b0;
                        wr_q <= 1'b0;
                        if (!we_q) begin
                            if (gnt_data_q)
                                d_rdata_q <= bus.memReadData;
                            else
                                if_data_q <= bus.memReadData;
                        end
                        if (gnt_data_q)
                            d_ack_q <= 1'b1;
                        else
                            if_ack_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                DONE: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    d_err_q  <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ifAck        = if_ack_q;
    assign bus.ifData       = if_data_q;
    assign bus.dAck         = d_ack_q;
    assign bus.dRData       = d_rdata_q;
    assign bus.dErr         = d_err_q;
    assign bus.memRead      = rd_q;
    assign bus.memWrite     = wr_q;
    assign bus.memAddress   = addr_q;
    assign bus.memWriteData = wdata_q;
endmodule
